// File: rtl/line_goal_tracker.sv
// line_goal_tracker: turns a "drive N crossings" command into a motor enable
// window, tracking the black-line crossing count from the crossing-counter
// stage. Reports done on reaching the goal and faults on count discontinuity.
// Optional stall watchdog is built when the macro STALL_WATCHDOG_EN is defined.
module line_goal_tracker #(
    parameter int STALL_CYCLES = 50000000,
    parameter int STALL_W      = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] conteo,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_target,
    output logic       cmd_ready,
    input  logic       abort,
    input  logic       done_ack,
    output logic       motor_en,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] progress
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_JUMP  = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;

    // The stall counter must be able to represent its terminal value.
    if (STALL_CYCLES < 1 || longint'(STALL_CYCLES) > (64'd1 << STALL_W)) begin : g_bad_stall_cfg
        $error("line_goal_tracker: STALL_W too small for STALL_CYCLES");
    end

    logic [1:0] state;
    logic [7:0] base;
    logic [7:0] target_r;
    logic [7:0] prev;

    logic [7:0] progress_next;
    logic       step;
    logic       jump;
    logic       goal;
    logic       stall_hit;
    logic       accept;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Per-cycle evaluation of count movement and goal distance.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        progress_next = conteo - base;
        step          = (conteo == prev + 8'd1);
        jump          = (conteo != prev) && !step;
        goal          = (progress_next >= target_r);
    end

`ifdef STALL_WATCHDOG_EN
    logic [STALL_W-1:0] stall_cnt;

    assign stall_hit = (state == S_RUN) && !step &&
                       (stall_cnt == STALL_W'(STALL_CYCLES - 1));

    // Stall counter: restarts on RUN entry and on each forward crossing.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (state == S_RUN) begin
            stall_cnt <= step ? '0 : stall_cnt + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // Run control FSM and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= S_IDLE;
            base       <= '0;
            target_r   <= '0;
            prev       <= '0;
            motor_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            progress   <= '0;
        end else begin
            prev <= conteo;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        progress <= '0;
                        if (cmd_target == 8'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            base     <= conteo;
                            target_r <= cmd_target;
                            motor_en <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    progress <= progress_next;
                    if (abort) begin
                        state    <= S_IDLE;
                        motor_en <= 1'b0;
                        busy     <= 1'b0;
                    end else if (jump) begin
                        state      <= S_FAULT;
                        motor_en   <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_JUMP;
                    end else if (goal) begin
                        state    <= S_DONE;
                        motor_en <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (stall_hit) begin
                        state      <= S_FAULT;
                        motor_en   <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_STALL;
                    end
                end
                S_DONE: begin
                    if (done_ack) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    if (done_ack) begin
                        state      <= S_IDLE;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_goal_tracker.sv
// tb_line_goal_tracker: scenario-driven bench with an expected-result queue.
// Stall expectations follow the STALL_WATCHDOG_EN macro of the build.
module tb_line_goal_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] conteo;
    logic       cmd_valid;
    logic [7:0] cmd_target;
    logic       cmd_ready;
    logic       abort;
    logic       done_ack;
    logic       motor_en;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] progress;

    typedef struct packed {
        logic       rdy;
        logic       me;
        logic       bz;
        logic       dn;
        logic       ft;
        logic [1:0] fc;
        logic [7:0] pg;
    } obs_t;

    typedef struct {
        logic [7:0] cnt;
        logic       rst;
        logic       vld;
        logic [7:0] tgt;
        logic       abt;
        logic       ack;
        obs_t       exp;
        string      nm;
    } step_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    line_goal_tracker #(.STALL_CYCLES(100), .STALL_W(26)) dut (
        .clock(clock), .reset(reset), .conteo(conteo),
        .cmd_valid(cmd_valid), .cmd_target(cmd_target), .cmd_ready(cmd_ready),
        .abort(abort), .done_ack(done_ack), .motor_en(motor_en), .busy(busy),
        .done(done), .fault(fault), .fault_code(fault_code), .progress(progress)
    );

    always #5 clock = ~clock;

    function automatic obs_t observed();
        return '{cmd_ready, motor_en, busy, done, fault, fault_code, progress};
    endfunction

    function automatic obs_t st_idle(logic [7:0] p);
        return '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, p};
    endfunction
    function automatic obs_t st_run(logic [7:0] p);
        return '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, p};
    endfunction
    function automatic obs_t st_done(logic [7:0] p);
        return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, p};
    endfunction
    function automatic obs_t st_fault(logic [1:0] c, logic [7:0] p);
        return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c, p};
    endfunction

    function automatic step_t mk(logic [7:0] c, logic r, logic v, logic [7:0] t,
                                 logic a, logic k, obs_t e, string n);
        step_t s;
        s.cnt = c; s.rst = r; s.vld = v; s.tgt = t; s.abt = a; s.ack = k;
        s.exp = e; s.nm = n;
        return s;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(step_t s);
        conteo = s.cnt; reset = s.rst; cmd_valid = s.vld; cmd_target = s.tgt;
        abort = s.abt; done_ack = s.ack;
    endtask

    task automatic test_reset();
        obs_t  e;
        string n;
        conteo = 8'd10; reset = 1'b1; cmd_valid = 1'b0; cmd_target = 8'd0;
        abort = 1'b0; done_ack = 1'b0;
        exp_q.push_back(st_idle(8'd0)); name_q.push_back("reset_state");
        tick(); tick();
        reset = 1'b0;
        tick();
        e = exp_q.pop_front(); n = name_q.pop_front(); total++;
        if (observed() !== e) begin
            bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
        end
    endtask

    task automatic test_basic_run();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd10, 0, 1, 8'd3, 0, 0, st_run(8'd0), "basic_accept"));
        for (int i = 0; i < 20; i++) s.push_back(mk(8'd10, 0, 0, 0, 0, 0, st_run(8'd0), "basic_hold0"));
        s.push_back(mk(8'd11, 0, 0, 0, 0, 0, st_run(8'd1), "basic_p1"));
        for (int i = 0; i < 20; i++) s.push_back(mk(8'd11, 0, 0, 0, 0, 0, st_run(8'd1), "basic_hold1"));
        s.push_back(mk(8'd12, 0, 0, 0, 0, 0, st_run(8'd2), "basic_p2"));
        for (int i = 0; i < 20; i++) s.push_back(mk(8'd12, 0, 0, 0, 0, 0, st_run(8'd2), "basic_hold2"));
        s.push_back(mk(8'd13, 0, 0, 0, 0, 0, st_done(8'd3), "basic_goal"));
        s.push_back(mk(8'd13, 0, 0, 0, 0, 0, st_done(8'd3), "basic_done_held"));
        s.push_back(mk(8'd13, 0, 0, 0, 0, 1, st_idle(8'd3), "basic_ack"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s[%0d]: got %h want %h", n, i, observed(), e);
            end
        end
    endtask

    task automatic test_wrap();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd254, 0, 0, 0, 0, 0, st_idle(8'd3), "wrap_idle"));
        s.push_back(mk(8'd254, 0, 1, 8'd4, 0, 0, st_run(8'd0), "wrap_accept"));
        s.push_back(mk(8'd255, 0, 0, 0, 0, 0, st_run(8'd1), "wrap_255"));
        s.push_back(mk(8'd0, 0, 0, 0, 0, 0, st_run(8'd2), "wrap_0"));
        s.push_back(mk(8'd1, 0, 0, 0, 0, 0, st_run(8'd3), "wrap_1"));
        s.push_back(mk(8'd2, 0, 0, 0, 0, 0, st_done(8'd4), "wrap_goal"));
        s.push_back(mk(8'd2, 0, 0, 0, 0, 1, st_idle(8'd4), "wrap_ack"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
            end
        end
    endtask

    task automatic test_zero_target();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd2, 0, 1, 8'd0, 0, 0, st_done(8'd0), "zero_done"));
        for (int i = 0; i < 3; i++) s.push_back(mk(8'd2, 0, 1, 8'd5, 0, 0, st_done(8'd0), "zero_backpressure"));
        s.push_back(mk(8'd2, 0, 0, 0, 0, 1, st_idle(8'd0), "zero_ack"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
            end
        end
    endtask

    task automatic test_abort();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd2, 0, 1, 8'd5, 0, 0, st_run(8'd0), "abort_accept"));
        s.push_back(mk(8'd3, 0, 0, 0, 0, 0, st_run(8'd1), "abort_p1"));
        s.push_back(mk(8'd4, 0, 0, 0, 0, 0, st_run(8'd2), "abort_p2"));
        s.push_back(mk(8'd5, 0, 0, 0, 1, 0, st_idle(8'd3), "abort_wins_goalstep"));
        s.push_back(mk(8'd5, 0, 0, 0, 0, 1, st_idle(8'd3), "ack_in_idle"));
        s.push_back(mk(8'd5, 0, 0, 0, 1, 0, st_idle(8'd3), "abort_in_idle"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
            end
        end
    endtask

    task automatic test_discontinuity();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd20, 0, 0, 0, 0, 0, st_idle(8'd3), "jump_idle"));
        s.push_back(mk(8'd20, 0, 1, 8'd10, 0, 0, st_run(8'd0), "jump_accept"));
        s.push_back(mk(8'd25, 0, 0, 0, 0, 0, st_fault(2'b01, 8'd5), "jump_fault"));
        s.push_back(mk(8'd25, 0, 1, 8'd3, 0, 0, st_fault(2'b01, 8'd5), "jump_no_accept"));
        s.push_back(mk(8'd25, 0, 0, 0, 0, 1, st_idle(8'd5), "jump_ack"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t  e;
        string n;
        int    cycles;
        logic  fault_seen;
        drive(mk(8'd25, 0, 1, 8'd2, 0, 0, st_run(8'd0), "stall_accept"));
        exp_q.push_back(st_run(8'd0)); name_q.push_back("stall_accept");
        tick();
        cmd_valid = 1'b0;
        e = exp_q.pop_front(); n = name_q.pop_front(); total++;
        if (observed() !== e) begin
            bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
        end
`ifdef STALL_WATCHDOG_EN
        exp_q.push_back(st_fault(2'b10, 8'd0)); name_q.push_back("stall_fault");
        cycles = 0;
        while (!fault && cycles < 300) begin
            tick();
            cycles++;
        end
        total++;
        if (cycles !== 100) begin
            bad++; $display("FAIL stall_latency: got %0d cycles want 100", cycles);
        end
        e = exp_q.pop_front(); n = name_q.pop_front(); total++;
        if (observed() !== e) begin
            bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
        end
        done_ack = 1'b1;
        exp_q.push_back(st_idle(8'd0)); name_q.push_back("stall_ack");
        tick();
        done_ack = 1'b0;
`else
        fault_seen = 1'b0;
        cycles = 0;
        repeat (10000) begin
            tick();
            cycles++;
            fault_seen = fault_seen | fault;
        end
        total++;
        if (fault_seen !== 1'b0) begin
            bad++; $display("FAIL no_stall_fault: got fault=%b within %0d cycles want 0", fault_seen, cycles);
        end
        exp_q.push_back(st_run(8'd0)); name_q.push_back("no_stall_still_run");
        e = exp_q.pop_front(); n = name_q.pop_front(); total++;
        if (observed() !== e) begin
            bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
        end
        abort = 1'b1;
        exp_q.push_back(st_idle(8'd0)); name_q.push_back("no_stall_abort");
        tick();
        abort = 1'b0;
`endif
        e = exp_q.pop_front(); n = name_q.pop_front(); total++;
        if (observed() !== e) begin
            bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
        end
    endtask

    task automatic test_reset_mid_run();
        step_t s[$];
        obs_t  e;
        string n;
        s.push_back(mk(8'd25, 0, 1, 8'd5, 0, 0, st_run(8'd0), "rst_accept"));
        s.push_back(mk(8'd26, 0, 0, 0, 0, 0, st_run(8'd1), "rst_p1"));
        s.push_back(mk(8'd26, 1, 0, 0, 0, 0, st_idle(8'd0), "rst_mid_run"));
        s.push_back(mk(8'd26, 0, 1, 8'd1, 0, 0, st_run(8'd0), "rst_new_accept"));
        s.push_back(mk(8'd27, 0, 0, 0, 0, 0, st_done(8'd1), "rst_new_goal"));
        s.push_back(mk(8'd27, 0, 0, 0, 0, 1, st_idle(8'd1), "rst_new_ack"));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp); name_q.push_back(s[i].nm);
            tick();
            e = exp_q.pop_front(); n = name_q.pop_front(); total++;
            if (observed() !== e) begin
                bad++; $display("FAIL %s: got %h want %h", n, observed(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_wrap();
        test_zero_target();
        test_abort();
        test_discontinuity();
        test_stall();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
